// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register-port master.
//   state_e      : master FSM encoding (also visible on the debug state port)
//   RESP_OKAY    : AXI response value that counts as success
//   PROT_DEFAULT : protection bits driven on AW/AR
//   resp_is_err  : true for any response other than OKAY
package axi_lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_reg_master_if.sv
// AXI4-Lite bus bundle between the register-port master and a peripheral.
// Clock and reset are not part of the bundle.
//   ADDR_W : byte address width
//   DATA_W : data width (strobe is DATA_W/8 bits)
// Modports:
//   master : drives AW/W/AR channels and B/R ready
//   slave  : drives the ready signals of AW/W/AR and the B/R channels
//
// Handshake semantics: a transfer happens on a rising clock edge where both
// valid and ready are high. Once valid is raised it stays high, with its
// payload unchanged, until that edge; ready may depend combinationally on valid.
interface axi_lite_reg_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_req_slot.sv
// Single-entry pending request register.
//   i_clk/i_rst : clock, synchronous active-high reset
//   i_load      : request pulse; captures i_payload when the slot is free
//                 (or is being emptied in this same cycle)
//   i_consume   : the FSM takes the pending request this cycle
//   o_pending   : slot holds an unconsumed request
//   o_payload   : stored request payload
//   o_ovf       : pulse when a request is dropped because the slot is full
module axi_lite_req_slot #(
  parameter int PW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [PW-1:0] i_payload,
  input  logic          i_consume,
  output logic          o_pending,
  output logic [PW-1:0] o_payload,
  output logic          o_ovf
);

  logic          r_pending;
  logic [PW-1:0] r_payload;

  assign o_pending = r_pending;
  assign o_payload = r_payload;
  assign o_ovf     = i_load && r_pending && !i_consume;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= 1'b0;
      r_payload <= '0;
    end else if (i_load && (!r_pending || i_consume)) begin
      // A load in the consume cycle refills the slot right away.
      r_pending <= 1'b1;
      r_payload <= i_payload;
    end else if (i_consume) begin
      r_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_lite_reg_master.sv
// AXI4-Lite master driven by a register-port request interface.
// A w_occur/r_occur pulse queues one write/read in a single-entry slot; the
// FSM turns it into one AXI-Lite transaction and reports completion with a
// one-cycle w_ready / r_valid pulse (plus w_err / r_err on a non-OKAY resp).
//   M_AXI_aclk/M_AXI_areset : clock, synchronous active-high reset
//   M_AXI                   : AXI4-Lite bus (master modport)
//   w_addr/w_data/w_occur   : write request (word address)
//   r_addr/r_occur          : read request (word address)
//   w_ready/w_err           : write completion pulse and error flag
//   r_valid/r_err/r_data    : read completion pulse, error flag, held data
//   busy                    : transaction in flight or request pending
//   req_ovf                 : sticky, a request was dropped on a full slot
//   dbg_state               : current FSM state (axi_lite_pkg::state_e encoding)
module axi_lite_reg_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH       = 10,
  parameter int DATA_WIDTH       = 16,
  parameter int M_AXI_ADDR_WIDTH = 32,
  parameter int M_AXI_DATA_WIDTH = 32,
  parameter logic [M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  M_AXI_aclk,
  input  logic                  M_AXI_areset,
  axi_lite_reg_master_if.master M_AXI,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_occur,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic                  r_occur,
  output logic                  w_ready,
  output logic                  r_valid,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  w_err,
  output logic                  r_err,
  output logic                  busy,
  output logic                  req_ovf,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_WR      = ST_WR;
  localparam logic [2:0] S_WR_RESP = ST_WR_RESP;
  localparam logic [2:0] S_RD_ADDR = ST_RD_ADDR;
  localparam logic [2:0] S_RD_DATA = ST_RD_DATA;

  // Word address -> byte address, wrapping modulo 2^M_AXI_ADDR_WIDTH.
  function automatic logic [M_AXI_ADDR_WIDTH-1:0] word_to_byte(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [M_AXI_ADDR_WIDTH-1:0] ext;
    ext = M_AXI_ADDR_WIDTH'(a);
    return BASE_ADDR + (ext << 2);
  endfunction

  logic [2:0]                  r_state;
  logic                        r_awvalid, r_wvalid, r_arvalid;
  logic [M_AXI_ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [M_AXI_DATA_WIDTH-1:0] r_wdata;
  logic                        r_w_ready, r_w_err, r_r_valid, r_r_err;
  logic [DATA_WIDTH-1:0]       r_r_data;
  logic                        r_req_ovf;

  logic                           w_wr_pend, w_rd_pend, w_wr_ovf, w_rd_ovf;
  logic                           w_wr_consume, w_rd_consume;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] w_wr_payload;
  logic [ADDR_WIDTH-1:0]          w_rd_payload;
  logic                           w_unused_rdata;

  // Write wins when both slots are pending.
  assign w_wr_consume = (r_state == S_IDLE) && w_wr_pend;
  assign w_rd_consume = (r_state == S_IDLE) && !w_wr_pend && w_rd_pend;

  axi_lite_req_slot #(.PW(ADDR_WIDTH + DATA_WIDTH)) u_wr_slot (
    .i_clk     (M_AXI_aclk),
    .i_rst     (M_AXI_areset),
    .i_load    (w_occur),
    .i_payload ({w_addr, w_data}),
    .i_consume (w_wr_consume),
    .o_pending (w_wr_pend),
    .o_payload (w_wr_payload),
    .o_ovf     (w_wr_ovf)
  );

  axi_lite_req_slot #(.PW(ADDR_WIDTH)) u_rd_slot (
    .i_clk     (M_AXI_aclk),
    .i_rst     (M_AXI_areset),
    .i_load    (r_occur),
    .i_payload (r_addr),
    .i_consume (w_rd_consume),
    .o_pending (w_rd_pend),
    .o_payload (w_rd_payload),
    .o_ovf     (w_rd_ovf)
  );

  always_ff @(posedge M_AXI_aclk) begin
    if (M_AXI_areset) begin
      r_state   <= S_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_awaddr  <= '0;
      r_araddr  <= '0;
      r_wdata   <= '0;
      r_w_ready <= 1'b0;
      r_w_err   <= 1'b0;
      r_r_valid <= 1'b0;
      r_r_err   <= 1'b0;
      r_r_data  <= '0;
      r_req_ovf <= 1'b0;
    end else begin
      r_w_ready <= 1'b0;
      r_w_err   <= 1'b0;
      r_r_valid <= 1'b0;
      r_r_err   <= 1'b0;
      r_req_ovf <= r_req_ovf | w_wr_ovf | w_rd_ovf;
      case (r_state)
        S_IDLE: begin
          if (w_wr_pend) begin
            r_state   <= S_WR;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_awaddr  <= word_to_byte(w_wr_payload[DATA_WIDTH +: ADDR_WIDTH]);
            r_wdata   <= M_AXI_DATA_WIDTH'(w_wr_payload[DATA_WIDTH-1:0]);
          end else if (w_rd_pend) begin
            r_state   <= S_RD_ADDR;
            r_arvalid <= 1'b1;
            r_araddr  <= word_to_byte(w_rd_payload);
          end
        end
        S_WR: begin
          // AW and W retire independently; leave once both valids are down.
          if (M_AXI.awready) r_awvalid <= 1'b0;
          if (M_AXI.wready)  r_wvalid  <= 1'b0;
          if (!r_awvalid && !r_wvalid) r_state <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (M_AXI.bvalid) begin
            r_w_ready <= 1'b1;
            r_w_err   <= resp_is_err(M_AXI.bresp);
            r_state   <= S_IDLE;
          end
        end
        S_RD_ADDR: begin
          if (M_AXI.arready) r_arvalid <= 1'b0;
          if (!r_arvalid) r_state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (M_AXI.rvalid) begin
            r_r_data  <= M_AXI.rdata[DATA_WIDTH-1:0];
            r_r_valid <= 1'b1;
            r_r_err   <= resp_is_err(M_AXI.rresp);
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bits of rdata above DATA_WIDTH are intentionally ignored.
  assign w_unused_rdata = ^M_AXI.rdata;

  assign M_AXI.awaddr  = r_awaddr;
  assign M_AXI.awprot  = PROT_DEFAULT;
  assign M_AXI.awvalid = r_awvalid;
  assign M_AXI.wdata   = r_wdata;
  assign M_AXI.wstrb   = '1;
  assign M_AXI.wvalid  = r_wvalid;
  assign M_AXI.bready  = (r_state == S_WR_RESP);
  assign M_AXI.araddr  = r_araddr;
  assign M_AXI.arprot  = PROT_DEFAULT;
  assign M_AXI.arvalid = r_arvalid;
  assign M_AXI.rready  = (r_state == S_RD_DATA);

  assign w_ready   = r_w_ready;
  assign w_err     = r_w_err;
  assign r_valid   = r_r_valid;
  assign r_err     = r_r_err;
  assign r_data    = r_r_data;
  assign req_ovf   = r_req_ovf;
  assign busy      = (r_state != S_IDLE) || w_wr_pend || w_rd_pend;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_axi_lite_reg_master.sv
// Bench for axi_lite_reg_master with a configurable-latency AXI-Lite slave.
module tb_axi_lite_reg_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  w_addr = '0;
  logic [15:0] w_data = '0;
  logic        w_occur = 1'b0;
  logic [9:0]  r_addr = '0;
  logic        r_occur = 1'b0;
  logic        w_ready, r_valid, w_err, r_err, busy, req_ovf;
  logic [15:0] r_data;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  axi_lite_reg_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_reg_master #(
    .ADDR_WIDTH(10), .DATA_WIDTH(16), .M_AXI_ADDR_WIDTH(32),
    .M_AXI_DATA_WIDTH(32), .BASE_ADDR(32'h8000_0000)
  ) dut (
    .M_AXI_aclk   (clk),
    .M_AXI_areset (rst),
    .M_AXI        (bus),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .w_occur      (w_occur),
    .r_addr       (r_addr),
    .r_occur      (r_occur),
    .w_ready      (w_ready),
    .r_valid      (r_valid),
    .r_data       (r_data),
    .w_err        (w_err),
    .r_err        (r_err),
    .busy         (busy),
    .req_ovf      (req_ovf),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- slave model ----------------
  int          cfg_aw_wait = 0, cfg_w_wait = 0, cfg_ar_wait = 0, cfg_r_wait = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic        aw_seen = 1'b0, w_seen = 1'b0, r_arm = 1'b0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;
  int          n_aw = 0;

  always_comb begin
    bus.awready = bus.awvalid && (aw_cnt >= cfg_aw_wait);
    bus.wready  = bus.wvalid && (w_cnt >= cfg_w_wait);
    bus.arready = bus.arvalid && (ar_cnt >= cfg_ar_wait);
  end

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; r_arm <= 1'b0;
      bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      bus.rvalid <= 1'b0; bus.rdata <= '0; bus.rresp <= 2'b00;
    end else begin
      if (bus.awvalid) begin
        if (bus.awready) begin
          aw_cnt <= 0; aw_seen <= 1'b1; cap_awaddr <= bus.awaddr; n_aw <= n_aw + 1;
        end else aw_cnt <= aw_cnt + 1;
      end
      if (bus.wvalid) begin
        if (bus.wready) begin
          w_cnt <= 0; w_seen <= 1'b1; cap_wdata <= bus.wdata; cap_wstrb <= bus.wstrb;
        end else w_cnt <= w_cnt + 1;
      end
      if (!bus.bvalid && (aw_seen || (bus.awvalid && bus.awready))
                      && (w_seen || (bus.wvalid && bus.wready))) begin
        bus.bvalid <= 1'b1; bus.bresp <= cfg_bresp; aw_seen <= 1'b0; w_seen <= 1'b0;
      end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if (bus.arvalid && !bus.arready) ar_cnt <= ar_cnt + 1;
      if (bus.arvalid && bus.arready) begin
        ar_cnt <= 0; r_arm <= 1'b1; r_cnt <= cfg_r_wait; cap_araddr <= bus.araddr;
      end
      if (r_arm && !bus.rvalid) begin
        if (r_cnt == 0) begin
          bus.rvalid <= 1'b1; bus.rdata <= cfg_rdata; bus.rresp <= cfg_rresp; r_arm <= 1'b0;
        end else r_cnt <= r_cnt - 1;
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
    end
  end

  // ---------------- protocol monitor: valid held + payload stable ----------------
  logic        p_rst = 1'b1;
  logic        p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
  int          mon_viol = 0;

  always @(posedge clk) begin
    p_rst <= rst;
    p_awv <= bus.awvalid; p_awr <= bus.awready; p_awaddr <= bus.awaddr;
    p_wv  <= bus.wvalid;  p_wr  <= bus.wready;  p_wdata  <= bus.wdata;
    p_arv <= bus.arvalid; p_arr <= bus.arready; p_araddr <= bus.araddr;
    if (!rst && !p_rst) begin
      if (p_awv && !p_awr && (!bus.awvalid || bus.awaddr != p_awaddr)) begin
        $display("FAIL aw_hold: awvalid=%0b awaddr=%h required 1/%h", bus.awvalid, bus.awaddr, p_awaddr);
        mon_viol <= mon_viol + 1;
      end
      if (p_wv && !p_wr && (!bus.wvalid || bus.wdata != p_wdata)) begin
        $display("FAIL w_hold: wvalid=%0b wdata=%h required 1/%h", bus.wvalid, bus.wdata, p_wdata);
        mon_viol <= mon_viol + 1;
      end
      if (p_arv && !p_arr && (!bus.arvalid || bus.araddr != p_araddr)) begin
        $display("FAIL ar_hold: arvalid=%0b araddr=%h required 1/%h", bus.arvalid, bus.araddr, p_araddr);
        mon_viol <= mon_viol + 1;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_rd;
    logic [9:0]  addr;
    logic [15:0] data;
    int          aw_wait, w_wait, ar_wait, r_wait;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  // One request from pulse (cycle 0) to completion; latency in cycles.
  task automatic run_vec(input vec_t v, input string name);
    int lat, pulses, aw_drop, w_drop;
    logic v2, got_err;
    logic [15:0] got_rd;
    cfg_aw_wait = v.aw_wait; cfg_w_wait = v.w_wait;
    cfg_ar_wait = v.ar_wait; cfg_r_wait = v.r_wait;
    cfg_bresp = v.resp; cfg_rresp = v.resp; cfg_rdata = v.rdata;
    tick();
    if (v.is_rd) begin r_addr = v.addr; r_occur = 1'b1; end
    else begin w_addr = v.addr; w_data = v.data; w_occur = 1'b1; end
    tick();
    w_occur = 1'b0; r_occur = 1'b0;
    lat = -1; pulses = 0; aw_drop = -1; w_drop = -1; v2 = 1'b0;
    got_err = 1'b0; got_rd = '0;
    for (int cyc = 1; cyc < 60; cyc++) begin
      if (cyc == 2) v2 = v.is_rd ? bus.arvalid : (bus.awvalid && bus.wvalid);
      if (!v.is_rd && cyc >= 2) begin
        if (!bus.awvalid && aw_drop < 0) aw_drop = cyc;
        if (!bus.wvalid && w_drop < 0) w_drop = cyc;
      end
      if (v.is_rd ? r_valid : w_ready) begin
        pulses++;
        if (lat < 0) begin
          lat = cyc;
          got_err = v.is_rd ? r_err : w_err;
          got_rd = r_data;
        end
      end
      if (lat >= 0 && cyc >= lat + 3) break;
      tick();
    end
    check({name, "_valid_at_2"}, 32'(v2), 32'd1);
    check({name, "_latency"}, lat, v.exp_lat);
    check({name, "_pulses"}, pulses, 1);
    check({name, "_err"}, 32'(got_err), 32'(v.exp_err));
    if (v.is_rd) begin
      check({name, "_araddr"}, cap_araddr, v.exp_addr);
      check({name, "_r_data"}, 32'(got_rd), 32'(v.exp_rdata));
      check({name, "_r_data_hold"}, 32'(r_data), 32'(v.exp_rdata));
    end else begin
      check({name, "_awaddr"}, cap_awaddr, v.exp_addr);
      check({name, "_wdata"}, cap_wdata, v.exp_wdata);
      check({name, "_wstrb"}, 32'(cap_wstrb), 32'hF);
      check({name, "_aw_drop"}, aw_drop, 3 + v.aw_wait);
      check({name, "_w_drop"}, w_drop, 3 + v.w_wait);
    end
    check({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int wr_cyc, rd_cyc, nw, nr, n_aw0;
    vec_t rv;

    vecs[0] = '{1'b0, 10'h005, 16'hBEEF, 0, 0, 0, 0, 2'b00, 32'h0,
                32'h8000_0014, 32'h0000_BEEF, 16'h0, 1'b0, 5};
    vecs[1] = '{1'b1, 10'h3FF, 16'h0, 0, 0, 0, 3, 2'b00, 32'h1234_ABCD,
                32'h8000_0FFC, 32'h0, 16'hABCD, 1'b0, 8};
    vecs[2] = '{1'b1, 10'h000, 16'h0, 0, 0, 0, 0, 2'b11, 32'hFFFF_0001,
                32'h8000_0000, 32'h0, 16'h0001, 1'b1, 5};
    vecs[3] = '{1'b0, 10'h3FF, 16'hFFFF, 4, 0, 0, 0, 2'b10, 32'h0,
                32'h8000_0FFC, 32'h0000_FFFF, 16'h0, 1'b1, 9};
    vecs[4] = '{1'b0, 10'h001, 16'h1234, 0, 2, 0, 0, 2'b00, 32'h0,
                32'h8000_0004, 32'h0000_1234, 16'h0, 1'b0, 7};
    vecs[5] = '{1'b1, 10'h002, 16'h0, 0, 0, 2, 1, 2'b01, 32'h0000_5A5A,
                32'h8000_0008, 32'h0, 16'h5A5A, 1'b1, 8};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_awvalid", 32'(bus.awvalid), 0);
    check("rst_wvalid", 32'(bus.wvalid), 0);
    check("rst_arvalid", 32'(bus.arvalid), 0);
    check("rst_bready", 32'(bus.bready), 0);
    check("rst_rready", 32'(bus.rready), 0);
    check("rst_pulses", {28'(0), w_ready, r_valid, w_err, r_err}, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_ovf", 32'(req_ovf), 0);
    check("rst_r_data", 32'(r_data), 0);
    check("rst_awaddr", bus.awaddr, 0);
    check("rst_araddr", bus.araddr, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_prot", {26'(0), bus.awprot, bus.arprot}, 0);

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    check("table_req_ovf", 32'(req_ovf), 0);

    // Simultaneous write and read: write first, then read
    cfg_aw_wait = 0; cfg_w_wait = 0; cfg_ar_wait = 0; cfg_r_wait = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = 32'hCAFE_7777;
    tick();
    w_addr = 10'h00A; w_data = 16'h1111; r_addr = 10'h00B;
    w_occur = 1'b1; r_occur = 1'b1;
    tick();
    w_occur = 1'b0; r_occur = 1'b0;
    wr_cyc = -1; rd_cyc = -1; nw = 0; nr = 0;
    for (int c = 1; c < 40; c++) begin
      if (w_ready) begin nw++; if (wr_cyc < 0) wr_cyc = c; end
      if (r_valid) begin nr++; if (rd_cyc < 0) rd_cyc = c; end
      tick();
    end
    check("both_w_ready_cycle", wr_cyc, 5);
    check("both_r_valid_cycle", rd_cyc, 9);
    check("both_w_pulses", nw, 1);
    check("both_r_pulses", nr, 1);
    check("both_awaddr", cap_awaddr, 32'h8000_0028);
    check("both_araddr", cap_araddr, 32'h8000_002C);
    check("both_r_data", 32'(r_data), 32'h7777);
    check("both_req_ovf", 32'(req_ovf), 0);

    // Overflow: in-flight write stalled on awready, two more pulses
    cfg_aw_wait = 6;
    n_aw0 = n_aw;
    tick();                                          // cycle 0
    w_addr = 10'h010; w_data = 16'hAAAA; w_occur = 1'b1;
    tick(); w_occur = 1'b0;                          // cycle 1
    tick();                                          // cycle 2
    tick(); w_addr = 10'h011; w_data = 16'hBBBB; w_occur = 1'b1;  // cycle 3
    tick(); w_addr = 10'h012; w_data = 16'hCCCC;                  // cycle 4
    tick(); w_occur = 1'b0;                          // cycle 5
    check("ovf_set", 32'(req_ovf), 1);
    nw = 0;
    for (int c = 5; c < 60; c++) begin
      if (w_ready) nw++;
      tick();
    end
    check("ovf_w_pulses", nw, 2);
    check("ovf_axi_writes", n_aw - n_aw0, 2);
    check("ovf_last_awaddr", cap_awaddr, 32'h8000_0044);
    check("ovf_last_wdata", cap_wdata, 32'h0000_BBBB);
    check("ovf_sticky", 32'(req_ovf), 1);
    check("ovf_busy", 32'(busy), 0);
    cfg_aw_wait = 0;

    // Reset during RD_DATA
    cfg_r_wait = 10; cfg_rdata = 32'h0000_9999;
    tick();
    r_addr = 10'h020; r_occur = 1'b1;                // cycle 0
    tick(); r_occur = 1'b0;                          // cycle 1
    repeat (4) tick();                               // cycle 5
    check("rstmid_in_rd_data", 32'(dbg_state), 32'd4);
    tick(); rst = 1'b1;                              // cycle 6
    tick(); rst = 1'b0;                              // cycle 7
    check("rstmid_state", 32'(dbg_state), 0);
    check("rstmid_rready", 32'(bus.rready), 0);
    check("rstmid_arvalid", 32'(bus.arvalid), 0);
    check("rstmid_araddr", bus.araddr, 0);
    check("rstmid_r_data", 32'(r_data), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_req_ovf", 32'(req_ovf), 0);
    nr = 0;
    for (int c = 0; c < 15; c++) begin
      if (r_valid) nr++;
      tick();
    end
    check("rstmid_no_r_valid", nr, 0);
    rv = '{1'b1, 10'h020, 16'h0, 0, 0, 0, 0, 2'b00, 32'h0000_4321,
           32'h8000_0080, 32'h0, 16'h4321, 1'b0, 5};
    run_vec(rv, "post_rst_rd");

    check("protocol_monitor", mon_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
